image_receiver: RTL and testbench
=================================

# image_receiver

Receives 12-bit images over the board's UART link and writes them pixel-by-pixel into a frame buffer. It is the receive end of the image link driven by `image_sender`: it deserialises 8N1 bytes, pairs them into pixels, and synchronises on the start marker pixel. It then emits `NUM_PIXELS` addressed pixel writes and a frame-complete pulse. It sits between a GPIO input pin and an image RAM or display buffer.

## Interface
- `NUM_PIXELS`, 100: image pixels per frame, excluding the marker.
- `CLK_FREQ`, 50_000_000: `clk` frequency in Hz.
- `BAUD_RATE`, 115200: UART bit rate.
- `START_PIXEL`, 12'h00A: marker pixel that opens a frame.
- `TIMEOUT_CYCLES`, 5_000_000: idle cycles tolerated mid-frame before abort.

- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `uart_in`  in  1  asynchronous serial line; idle high.
- `pixel_out`  out  12  received pixel, {R[3:0], G[3:0], B[3:0]}.
- `address`  out  17  frame-buffer address of `pixel_out`, 0..NUM_PIXELS-1.
- `pixel_valid`  out  1  one-cycle write strobe for `pixel_out`/`address`.
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame.
- `frame_error`  out  1  one-cycle pulse on framing error or timeout abort.
- `rx_busy`  out  1  high while in RECEIVE state.

## Operation
- Input conditioning: `uart_in` passes through a 2-flop synchroniser before any use.
- Bit timing:
  - Divisor `DIV = CLK_FREQ / BAUD_RATE`, truncated (434 at defaults).
  - A falling edge starts the byte receiver. The line is re-checked at `DIV/2`; if it is high, the event is a false start and the receiver returns to idle.
  - The receiver samples 8 data bits, LSB first, at `DIV` intervals, then the stop bit.
  - Stop bit = 0: the byte is discarded and a framing error is raised.
- Byte pairing: each pixel is two bytes, high byte first.
  - Byte 0 carries `{xxxx, pixel[11:8]}`; its upper nibble is ignored.
  - Byte 1 carries `pixel[7:0]`.
  - A byte-phase flag tracks which byte is expected next and is cleared on every state change.
- Frame FSM states:
  - IDLE:
    - Every completed pixel is compared with `START_PIXEL`.
    - On a match, go to RECEIVE and set `address` to 0.
    - On a mismatch, drop the pixel and reset the byte phase only if it was byte 1; no output strobe is generated.
  - RECEIVE:
    - Each completed pixel drives `pixel_valid` with the current `address`, then `address` increments.
    - A pixel equal to `START_PIXEL` is ordinary data in this state.
    - After pixel index `NUM_PIXELS-1` is written, go to DONE.
  - DONE: pulse `frame_done` for one cycle, return to IDLE, and hold `address` at its final value.
- Errors:
  - A framing error in RECEIVE pulses `frame_error` and returns to IDLE. Pixels already written are not retracted.
  - A framing error in IDLE pulses `frame_error` and clears the byte phase.
- Reset mid-operation: `rst` aborts any byte or frame in progress. No strobe is emitted for the partial pixel.

## Timing
- Reset values: `pixel_out`=0, `address`=0, `pixel_valid`=0, `frame_done`=0, `frame_error`=0, `rx_busy`=0; FSM in IDLE; byte phase 0.
- `pixel_valid` asserts exactly 1 cycle after the stop-bit sample of byte 1 and lasts 1 cycle. `pixel_out` and `address` are stable in that cycle.
- `address` increments in the cycle after `pixel_valid`.
- `frame_done` asserts 1 cycle after the final `pixel_valid`.
- `rx_busy` rises in the cycle after the marker completes and falls in the `frame_done` cycle.
- `frame_error` asserts 1 cycle after a bad stop-bit sample.
- Simultaneous events: a framing error on byte 1 of the last pixel yields `frame_error` and no `frame_done`.
- Back-to-back bytes with zero idle between the stop bit and the next start bit are received without loss.

## Configuration
- `IMAGE_RECEIVER_TIMEOUT_EN` defined:
  - A counter clears on every completed byte and counts while in RECEIVE, or while the byte phase is 1 in IDLE.
  - On reaching `TIMEOUT_CYCLES` it pulses `frame_error`, returns to IDLE and clears the byte phase.
- Undefined: no timeout logic; a stalled frame waits indefinitely for more bytes. `TIMEOUT_CYCLES` is ignored.

## Test plan
- Marker 0x00,0x0A followed by 100 pixel pairs 0x0F,0x00 -> 100 `pixel_valid` strobes with `pixel_out`=12'hF00 at addresses 0..99, then one `frame_done`.
- Bytes 0x03,0x21 sent before the marker -> no strobes. A subsequent marker plus frame is received normally starting at address 0.
- Mid-frame pixel 0x00,0x0A (at address 5) -> written as data 12'h00A at address 5; no resynchronisation occurs.
- Stop bit forced low on byte 1 of pixel 40 -> `frame_error` pulse, `rx_busy` falls, no `frame_done`. The next marker restarts at address 0.
- With `IMAGE_RECEIVER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=1000: the line is idled for 1000 cycles after pixel 10 -> `frame_error` pulse, FSM in IDLE.
- `rst` asserted for 1 cycle midway through a byte, then marker plus frame -> all outputs are 0 during reset and the frame completes with 100 correct writes.

Source files
------------

// File: rtl/image_receiver.sv
// image_receiver: 8N1 UART byte receiver that pairs bytes into 12-bit pixels and writes
// NUM_PIXELS addressed pixels after each START_PIXEL marker. Define IMAGE_RECEIVER_TIMEOUT_EN for stall abort.
module image_receiver #(
    parameter int          NUM_PIXELS     = 100,
    parameter int          CLK_FREQ       = 50_000_000,
    parameter int          BAUD_RATE      = 115200,
    parameter logic [11:0] START_PIXEL    = 12'h00A,
    parameter int          TIMEOUT_CYCLES = 5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_in,
    output logic [11:0] pixel_out,
    output logic [16:0] address,
    output logic        pixel_valid,
    output logic        frame_done,
    output logic        frame_error,
    output logic        rx_busy
);
    // state   | meaning
    // IDLE    | pairing bytes, hunting for START_PIXEL
    // RECEIVE | writing pixels to address 0..NUM_PIXELS-1
    // DONE    | one-cycle frame_done, then back to IDLE

    localparam int          DIV       = CLK_FREQ / BAUD_RATE;
    localparam int          CW        = $clog2(DIV + 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);
    localparam logic [16:0] LAST_ADDR = 17'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {IDLE, RECEIVE, DONE} state_t;

    logic uart_s1, uart_s2, uart_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            uart_s1   <= 1'b1;
            uart_s2   <= 1'b1;
            uart_prev <= 1'b1;
        end else begin
            uart_s1   <= uart_in;
            uart_s2   <= uart_s1;
            uart_prev <= uart_s2;
        end
    end

    rx_state_t     rx_state, rx_state_n;
    logic [CW-1:0] bit_cnt, bit_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    rx_shift, rx_shift_n;
    logic          bit_tick, byte_ok, byte_bad;

    assign bit_tick = (bit_cnt == '0);
    assign byte_ok  = (rx_state == RX_STOP) && bit_tick && uart_s2;
    assign byte_bad = (rx_state == RX_STOP) && bit_tick && !uart_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_n;
            bit_cnt  <= bit_cnt_n;
            bit_idx  <= bit_idx_n;
            rx_shift <= rx_shift_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        bit_cnt_n  = bit_tick ? bit_cnt : bit_cnt - 1'b1;
        bit_idx_n  = bit_idx;
        rx_shift_n = rx_shift;
        case (rx_state)
            RX_IDLE: if (uart_prev && !uart_s2) begin
                rx_state_n = RX_START;
                bit_cnt_n  = HALF_LOAD;
            end
            RX_START: if (bit_tick) begin
                if (uart_s2) begin
                    rx_state_n = RX_IDLE;
                end else begin
                    rx_state_n = RX_DATA;
                    bit_cnt_n  = FULL_LOAD;
                    bit_idx_n  = 3'd0;
                end
            end
            RX_DATA: if (bit_tick) begin
                rx_shift_n = {uart_s2, rx_shift[7:1]};
                bit_cnt_n  = FULL_LOAD;
                bit_idx_n  = bit_idx + 3'd1;
                if (bit_idx == 3'd7) rx_state_n = RX_STOP;
            end
            RX_STOP: if (bit_tick) rx_state_n = RX_IDLE;
            default: rx_state_n = RX_IDLE;
        endcase
    end

    state_t      state, state_n;
    logic        byte_phase, phase_n;
    logic [3:0]  hi_nib, hi_n;
    logic [16:0] addr_n;
    logic [11:0] pix_n;
    logic        pv_n, done_n, err_n, timeout;

`ifdef IMAGE_RECEIVER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
    logic          to_run;

    assign to_run  = (state == RECEIVE) || ((state == IDLE) && byte_phase);
    assign timeout = to_run && (to_cnt == TW'(1));

    always_ff @(posedge clk) begin
        if (rst || byte_ok || byte_bad || !to_run || timeout) to_cnt <= TW'(TIMEOUT_CYCLES);
        else                                                  to_cnt <= to_cnt - 1'b1;
    end
`else
    // Stall abort not built; a stalled frame waits for more bytes.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            byte_phase  <= 1'b0;
            hi_nib      <= '0;
            address     <= '0;
            pixel_out   <= '0;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_n;
            byte_phase  <= phase_n;
            hi_nib      <= hi_n;
            address     <= addr_n;
            pixel_out   <= pix_n;
            pixel_valid <= pv_n;
            frame_done  <= done_n;
            frame_error <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        phase_n = byte_phase;
        hi_n    = hi_nib;
        addr_n  = address;
        pix_n   = pixel_out;
        pv_n    = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: if (byte_ok) begin
                if (!byte_phase) begin
                    hi_n    = rx_shift[3:0];
                    phase_n = 1'b1;
                end else begin
                    phase_n = 1'b0;
                    if ({hi_nib, rx_shift} == START_PIXEL) begin
                        state_n = RECEIVE;
                        addr_n  = '0;
                    end
                end
            end
            RECEIVE: begin
                if (pixel_valid) begin
                    if (address == LAST_ADDR) state_n = DONE;
                    else                      addr_n  = address + 17'd1;
                end
                if (byte_ok) begin
                    if (!byte_phase) begin
                        hi_n    = rx_shift[3:0];
                        phase_n = 1'b1;
                    end else begin
                        phase_n = 1'b0;
                        pix_n   = {hi_nib, rx_shift};
                        pv_n    = 1'b1;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Bad stop bit or stall: drop any half pixel and abandon the frame.
        if (byte_bad || timeout) begin
            err_n   = 1'b1;
            phase_n = 1'b0;
            if (state == RECEIVE) state_n = IDLE;
        end
        done_n = (state == RECEIVE) && (state_n == DONE);
        if (state_n != state) phase_n = 1'b0;
    end

    assign rx_busy = (state == RECEIVE);

endmodule

// File: tb/tb_image_receiver.sv
// Randomized bench for image_receiver: drives 8N1 bytes and checks pulses against a byte-level model.
module tb_image_receiver;
    localparam int          NUM   = 12;
    localparam int          CLKF  = 1_600_000;
    localparam int          BAUD  = 100_000;
    localparam int          BIT   = CLKF / BAUD;
    localparam int          TO    = 1000;
    localparam logic [11:0] START = 12'h00A;

    logic        clk, rst, uart_in;
    logic [11:0] pixel_out;
    logic [16:0] address;
    logic        pixel_valid, frame_done, frame_error, rx_busy;

    image_receiver #(
        .NUM_PIXELS(NUM), .CLK_FREQ(CLKF), .BAUD_RATE(BAUD),
        .START_PIXEL(START), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .uart_in(uart_in),
        .pixel_out(pixel_out), .address(address), .pixel_valid(pixel_valid),
        .frame_done(frame_done), .frame_error(frame_error), .rx_busy(rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  kind;   // one-hot {error, done, pixel}
        logic [16:0] addr;
        logic [11:0] pix;
    } evt_t;

    evt_t exp_q[$];
    int   n_cmp, n_err;
    bit   m_in_frame, m_phase;
    int   m_addr;
    logic [3:0] m_hi;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_in_frame = 0;
        m_phase    = 0;
        m_addr     = 0;
    endtask

    // Reference: bytes pair into pixels; marker opens a frame of NUM writes.
    task automatic model_byte(input logic [7:0] b, input bit ok);
        logic [11:0] p;
        if (!ok) begin
            exp_q.push_back('{3'b100, 17'd0, 12'd0});
            m_in_frame = 0;
            m_phase    = 0;
        end else if (!m_phase) begin
            m_hi    = b[3:0];
            m_phase = 1;
        end else begin
            m_phase = 0;
            p = {m_hi, b};
            if (!m_in_frame) begin
                if (p == START) begin
                    m_in_frame = 1;
                    m_addr     = 0;
                end
            end else begin
                exp_q.push_back('{3'b001, 17'(m_addr), p});
                if (m_addr == NUM - 1) begin
                    exp_q.push_back('{3'b010, 17'd0, 12'd0});
                    m_in_frame = 0;
                end else begin
                    m_addr++;
                end
            end
        end
    endtask

    task automatic drive_bit(input logic v);
        uart_in = v;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ok);
        int gap;
        model_byte(b, ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(ok);
        if (!ok) drive_bit(1'b1);
        gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
        repeat (gap) @(negedge clk);
        check_eq("rx_busy", rx_busy, m_in_frame);
    endtask

    task automatic send_pixel(input logic [11:0] p, input bit bad1);
        logic [3:0] junk;
        junk = 4'($urandom);
        send_byte({junk, p[11:8]}, 1'b1);
        send_byte(p[7:0], !bad1);
    endtask

    // mode 0: all 12'hF00, 1: random, 2: random with a marker-valued pixel at index 5
    task automatic send_frame(input int mode, input int bad_at);
        logic [11:0] p;
        send_pixel(START, 1'b0);
        for (int i = 0; i < NUM; i++) begin
            p = (mode == 0) ? 12'hF00 : 12'($urandom);
            if (mode == 2 && i == 5) p = START;
            send_pixel(p, i == bad_at);
            if (i == bad_at) break;
        end
    endtask

    task automatic settle();
        repeat (2 * BIT) @(negedge clk);
        check_eq("pending", exp_q.size(), 0);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_pix"}, pixel_out, 0);
        check_eq({tag, "_addr"}, address, 0);
        check_eq({tag, "_pv"}, pixel_valid, 0);
        check_eq({tag, "_done"}, frame_done, 0);
        check_eq({tag, "_err"}, frame_error, 0);
        check_eq({tag, "_busy"}, rx_busy, 0);
    endtask

    bit          prev_pv;
    logic [16:0] prev_addr;
    evt_t        e;

    always @(negedge clk) begin
        if (rst) begin
            prev_pv = 0;
        end else begin
            if (prev_pv) begin
                check_eq("pv_width", pixel_valid, 0);
                if (prev_addr != 17'(NUM - 1)) check_eq("addr_inc", address, prev_addr + 17'd1);
            end
            if (frame_done) begin
                check_eq("done_after_pv", prev_pv, 1);
                check_eq("busy_at_done", rx_busy, 0);
            end
            if (pixel_valid || frame_done || frame_error) begin
                check_eq("evt_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("evt_kind", {frame_error, frame_done, pixel_valid}, e.kind);
                    if (e.kind == 3'b001) begin
                        check_eq("pix_addr", address, e.addr);
                        check_eq("pix_data", pixel_out, e.pix);
                    end
                end
            end
            prev_pv   = pixel_valid;
            prev_addr = address;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        int n_junk;
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b1;
        uart_in = 1'b1;
        m_reset();
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;
        @(negedge clk);
        check_quiet("post_reset");

        send_frame(0, -1);
        settle();

        send_byte(8'h03, 1'b1);
        send_byte(8'h21, 1'b1);
        send_frame(1, -1);
        settle();

        send_frame(2, -1);
        settle();

        send_frame(1, 8);
        settle();
        check_eq("busy_after_err", rx_busy, 0);
        send_frame(1, -1);
        settle();

        send_byte(8'h5A, 1'b0);
        send_frame(1, -1);
        settle();

        send_pixel(START, 1'b0);
        for (int i = 0; i < 3; i++) send_pixel(12'($urandom), 1'b0);
        check_eq("pending_pre_rst", exp_q.size(), 0);
        uart_in = 1'b0;
        repeat (BIT + BIT / 2) @(negedge clk);
        rst     = 1'b1;
        uart_in = 1'b1;
        m_reset();
        @(negedge clk);
        check_quiet("mid_reset");
        rst = 1'b0;
        repeat (2 * BIT) @(negedge clk);
        send_frame(0, -1);
        settle();

        for (int r = 0; r < 3; r++) begin
            n_junk = 2 * $urandom_range(0, 2);
            for (int j = 0; j < n_junk; j++) send_byte(8'($urandom), 1'b1);
            send_frame(1, -1);
            settle();
        end

`ifdef IMAGE_RECEIVER_TIMEOUT_EN
        send_pixel(START, 1'b0);
        for (int i = 0; i <= 10; i++) send_pixel(12'($urandom), 1'b0);
        exp_q.push_back('{3'b100, 17'd0, 12'd0});
        m_reset();
        repeat (TO + 2 * BIT) @(negedge clk);
        check_eq("timeout_pending", exp_q.size(), 0);
        check_eq("timeout_busy", rx_busy, 0);
        send_frame(1, -1);
        settle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
